// File: rtl/frame_seq_if.sv
// Byte-stream handshake bundle for frame_seq: RX input, packer output,
// unpacker result input and UART TX result output.
interface frame_seq_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] res_data_i;
  logic       res_valid_i;
  logic       res_ready_o;
  logic [7:0] res_data_o;
  logic       res_valid_o;
  logic       res_ready_i;

  // The sequencer side.
  modport slave (
    input  data_i, valid_i, ready_i, res_data_i, res_valid_i, res_ready_i,
    output ready_o, data_o, valid_o, res_ready_o, res_data_o, res_valid_o
  );

  // The surrounding datapath / environment side.
  modport master (
    output data_i, valid_i, ready_i, res_data_i, res_valid_i, res_ready_i,
    input  ready_o, data_o, valid_o, res_ready_o, res_data_o, res_valid_o
  );
endinterface

// File: rtl/frame_seq.sv
// Frame sequencer: locks on a sync byte, admits one RGB frame, flushes the
// line-buffer priming, and forwards one frame of results. Optional idle-abort
// is enabled with the FRAME_SEQ_TIMEOUT_EN macro.
module frame_seq #(
  parameter int         LINE_W_P    = 640,
  parameter int         FRAME_H_P   = 480,
  parameter int         PRIME_PIX_P = LINE_W_P + 1,
  parameter logic [7:0] SYNC_P      = 8'hA5
`ifdef FRAME_SEQ_TIMEOUT_EN
  , parameter int       TIMEOUT_P   = 2**20
`endif
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  frame_seq_if.slave   bus,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int N     = 3 * LINE_W_P * FRAME_H_P;
  localparam int P     = 3 * PRIME_PIX_P;
  localparam int CNT_W = $clog2(N + P + 1);

  localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_ALL  = CNT_W'(N + P - 1);
  localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(P);
  localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(N + P);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] in_cnt, out_cnt;

  logic active, res_drop, res_fwd;
  logic sync_hs, in_hs, res_hs, out_full_nxt, abort;

  assign active   = (state == S_STREAM) || (state == S_FLUSH) || (state == S_DRAIN);
  assign res_drop = active && (out_cnt < PRIME_CNT);
  assign res_fwd  = active && (out_cnt >= PRIME_CNT) && (out_cnt != TOTAL);

  assign sync_hs = (state == S_IDLE) && bus.valid_i && (bus.data_i == SYNC_P);
  assign in_hs   = ((state == S_STREAM) && bus.valid_i && bus.ready_i) ||
                   ((state == S_FLUSH) && bus.ready_i);
  assign res_hs  = (res_drop && bus.res_valid_i) ||
                   (res_fwd && bus.res_valid_i && bus.res_ready_i);

  // Looks at the count including this cycle's handshake so done follows
  // the final result byte by exactly one cycle.
  assign out_full_nxt = (out_cnt == TOTAL) || (res_fwd && res_hs && (out_cnt == LAST_ALL));

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_P + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_P - 1);

  logic [TO_W-1:0] idle_cnt;

  assign abort = active && !(in_hs || res_hs) && (idle_cnt == TO_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      idle_cnt <= '0;
    else if (!active || in_hs || res_hs || abort)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + TO_W'(1);
  end
`else
  assign abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (sync_hs || abort) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_hs)  in_cnt  <= in_cnt + CNT_W'(1);
      if (res_hs) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // NOTE: the default assignment up front keeps this block purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sync_hs) state_nxt = S_STREAM;
      S_STREAM: if (in_hs && (in_cnt == LAST_IN)) state_nxt = S_FLUSH;
      S_FLUSH:  if (in_hs && (in_cnt == LAST_ALL))
                  state_nxt = out_full_nxt ? S_DONE : S_DRAIN;
      S_DRAIN:  if (out_full_nxt) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_comb begin
    bus.ready_o     = 1'b0;
    bus.valid_o     = 1'b0;
    bus.data_o      = 8'h00;
    bus.res_ready_o = 1'b1;
    bus.res_valid_o = 1'b0;
    bus.res_data_o  = 8'h00;
    busy_o          = (state != S_IDLE);
    done_o          = (state == S_DONE);
    err_o           = abort;

    case (state)
      S_IDLE:   bus.ready_o = 1'b1;
      S_STREAM: begin
        bus.ready_o = bus.ready_i;
        bus.valid_o = bus.valid_i;
        bus.data_o  = bus.data_i;
      end
      S_FLUSH:  bus.valid_o = 1'b1;
      default:  ;
    endcase

    // Priming results and strays are swallowed; only the frame window passes.
    if (res_fwd) begin
      bus.res_ready_o = bus.res_ready_i;
      bus.res_valid_o = bus.res_valid_i;
      bus.res_data_o  = bus.res_data_i;
    end
  end

endmodule

// File: tb/tb_frame_seq.sv
// Directed bench for frame_seq with W=4, H=2, PRIME=5 (N=24, P=15).
module tb_frame_seq;
  localparam int N = 24;
  localparam int P = 15;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic busy, done, err;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  frame_seq_if bus ();

  frame_seq #(
    .LINE_W_P    (4),
    .FRAME_H_P   (2),
    .PRIME_PIX_P (5),
    .SYNC_P      (8'hA5)
`ifdef FRAME_SEQ_TIMEOUT_EN
    , .TIMEOUT_P (16)
`endif
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err)
  );

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
  } in_t;

  typedef struct packed {
    logic       ready_o;
    logic       valid_o;
    logic [7:0] data_o;
    logic       res_ready_o;
    logic       res_valid_o;
    logic [7:0] res_data_o;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  localparam int NV = 83;
  vec_t tbl [NV];
  int   nv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic in_t mk_in(logic v, logic [7:0] d, logic r,
                                logic rv, logic [7:0] rd, logic rr);
    in_t t;
    t = '{valid: v, data: d, ready: r, res_valid: rv, res_data: rd, res_ready: rr};
    return t;
  endfunction

  function automatic out_t mk_out(logic rdy, logic vld, logic [7:0] d, logic rrdy,
                                  logic rvld, logic [7:0] rd, logic b, logic dn);
    out_t t;
    t = '{ready_o: rdy, valid_o: vld, data_o: d, res_ready_o: rrdy,
          res_valid_o: rvld, res_data_o: rd, busy: b, done: dn, err: 1'b0};
    return t;
  endfunction

  function automatic out_t sample();
    out_t t;
    t = '{ready_o: bus.ready_o, valid_o: bus.valid_o, data_o: bus.data_o,
          res_ready_o: bus.res_ready_o, res_valid_o: bus.res_valid_o,
          res_data_o: bus.res_data_o, busy: busy, done: done, err: err};
    return t;
  endfunction

  task automatic add(input in_t i, input out_t e);
    tbl[nv] = '{in: i, exp: e};
    nv++;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input in_t v);
    @(negedge clk);
    bus.valid_i     = v.valid;
    bus.data_i      = v.data;
    bus.ready_i     = v.ready;
    bus.res_valid_i = v.res_valid;
    bus.res_data_i  = v.res_data;
    bus.res_ready_i = v.res_ready;
  endtask

  task automatic fill_table();
    out_t idle_exp;
    nv = 0;
    idle_exp = mk_out(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add(mk_in(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0), idle_exp);
    add(mk_in(1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0), idle_exp);
    add(mk_in(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0), idle_exp);
    for (int k = 0; k < N; k++)
      add(mk_in(1'b1, 8'(k), 1'b1, 1'b0, 8'h00, 1'b0),
          mk_out(1'b1, 1'b1, 8'(k), 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
    for (int k = 0; k < P; k++)
      add(mk_in(1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0),
          mk_out(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
    for (int j = 0; j < N + P; j++) begin
      if (j < P)
        add(mk_in(1'b0, 8'h00, 1'b0, 1'b1, 8'(100 + j), 1'b1),
            mk_out(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
      else
        add(mk_in(1'b0, 8'h00, 1'b0, 1'b1, 8'(100 + j), 1'b1),
            mk_out(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'(100 + j), 1'b1, 1'b0));
    end
    add(mk_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0),
        mk_out(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1));
    add(mk_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0), idle_exp);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < nv; i++) begin
      drive(tbl[i].in);
      #1;
      check($sformatf("%s_vec%0d", tag, i), 32'(sample()), 32'(tbl[i].exp));
    end
  endtask

  // Random stalls on both ready inputs; byte streams collected and compared.
  task automatic stall_test();
    logic [7:0] got_in[$];
    logic [7:0] got_res[$];
    int   in_k = 0;
    int   res_j = 0;
    bit   finished = 1'b0;
    logic pv_stall = 1'b0, pr_stall = 1'b0;
    logic [7:0] pv_d = 8'h00, pr_d = 8'h00;

    drive(mk_in(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0));
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      bus.ready_i     = 1'($urandom_range(0, 1));
      bus.res_ready_i = 1'($urandom_range(0, 1));
      bus.valid_i     = (in_k < N);
      bus.data_i      = 8'(in_k);
      bus.res_valid_i = (res_j < N + P);
      bus.res_data_i  = 8'(100 + res_j);
      #1;
      if (pv_stall) check("s3_valid_hold", 32'({bus.valid_o, bus.data_o}), 32'({1'b1, pv_d}));
      if (pr_stall) check("s3_res_hold", 32'({bus.res_valid_o, bus.res_data_o}), 32'({1'b1, pr_d}));
      pv_stall = bus.valid_o && !bus.ready_i;
      pv_d     = bus.data_o;
      pr_stall = bus.res_valid_o && !bus.res_ready_i;
      pr_d     = bus.res_data_o;
      if (bus.valid_o && bus.ready_i) got_in.push_back(bus.data_o);
      if (bus.valid_i && bus.ready_o) in_k++;
      if (bus.res_valid_o && bus.res_ready_i) got_res.push_back(bus.res_data_o);
      if (bus.res_valid_i && bus.res_ready_o) res_j++;
      if (done) finished = 1'b1;
    end
    check("s3_done_seen", 32'(finished), 32'(1));
    check("s3_in_count", 32'(got_in.size()), 32'(N + P));
    check("s3_res_count", 32'(got_res.size()), 32'(N));
    for (int i = 0; i < got_in.size() && i < N + P; i++)
      check($sformatf("s3_in%0d", i), 32'(got_in[i]), (i < N) ? 32'(i) : 32'(0));
    for (int i = 0; i < got_res.size() && i < N; i++)
      check($sformatf("s3_res%0d", i), 32'(got_res[i]), 32'(115 + i));
    drive(mk_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    #1;
    check("s3_back_idle", 32'({busy, done}), 32'(0));
  endtask

  task automatic sync_in_frame_test();
    logic [7:0] b;
    drive(mk_in(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0));
    for (int k = 0; k < N; k++) begin
      b = (k == 7) ? 8'hA5 : 8'(8'h30 + k);
      drive(mk_in(1'b1, b, 1'b1, 1'b0, 8'h00, 1'b0));
      #1;
      check($sformatf("s4_data%0d", k), 32'({bus.valid_o, bus.data_o}), 32'({1'b1, b}));
    end
    // A sync byte mid-frame must not restart the count: flush begins on time.
    drive(mk_in(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0));
    #1;
    check("s4_flush_entry", 32'({bus.ready_o, bus.valid_o, bus.data_o}), 32'({1'b0, 1'b1, 8'h00}));
    for (int k = 1; k < P; k++) drive(mk_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
    for (int j = 0; j < N + P; j++) drive(mk_in(1'b0, 8'h00, 1'b0, 1'b1, 8'(j), 1'b1));
    for (int e = 0; e < 3; e++) begin
      drive(mk_in(1'b0, 8'h00, 1'b0, 1'b1, 8'hEE, 1'b1));
      #1;
      check($sformatf("s4_stray%0d", e), 32'({bus.res_ready_o, bus.res_valid_o, bus.res_data_o}),
            32'({1'b1, 1'b0, 8'h00}));
      check($sformatf("s4_done%0d", e), 32'(done), (e == 0) ? 32'(1) : 32'(0));
    end
  endtask

  task automatic reset_mid_frame_test();
    drive(mk_in(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0));
    for (int k = 0; k < 10; k++) drive(mk_in(1'b1, 8'(k), 1'b1, 1'b0, 8'h00, 1'b0));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("s5_rst", 32'({busy, bus.ready_o, bus.valid_o, bus.res_ready_o}), 32'({1'b0, 1'b1, 1'b0, 1'b1}));
    @(negedge clk);
    rstn = 1'b1;
    run_table("s5");
  endtask

`ifdef FRAME_SEQ_TIMEOUT_EN
  task automatic timeout_test();
    drive(mk_in(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0));
    for (int k = 0; k < 5; k++) drive(mk_in(1'b1, 8'(k), 1'b1, 1'b0, 8'h00, 1'b0));
    for (int k = 1; k <= 16; k++) begin
      drive(mk_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1));
      #1;
      check($sformatf("s6_idle%0d", k), 32'({err, done}), (k == 16) ? 32'(2) : 32'(0));
    end
    drive(mk_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1));
    #1;
    check("s6_after", 32'({busy, err, done, bus.ready_o}), 32'({1'b0, 1'b0, 1'b0, 1'b1}));
  endtask
`endif

  initial begin
    bus.valid_i     = 1'b1;
    bus.data_i      = 8'h5A;
    bus.ready_i     = 1'b1;
    bus.res_valid_i = 1'b1;
    bus.res_data_i  = 8'h77;
    bus.res_ready_i = 1'b0;
    #2;
    check("reset_state", 32'(sample()),
          32'(mk_out(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0)));
    @(negedge clk);
    rstn = 1'b1;

    fill_table();
    run_table("s12");
    stall_test();
    sync_in_frame_test();
    reset_mid_frame_test();
`ifdef FRAME_SEQ_TIMEOUT_EN
    timeout_test();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
